// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and long-op decode for alu_seq.
// Divider support is compiled in only when ALU_SEQ_DIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REM  = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_e;

    typedef struct packed {
        logic div;
        logic sgn;
        logic rem;
    } iter_sel_t;

    function automatic iter_sel_t iter_sel(input logic [3:0] op);
        iter_sel_t s;
        s.div = (op != OP_MUL);
        s.sgn = (op == OP_DIV) || (op == OP_REM);
        s.rem = (op == OP_REM) || (op == OP_REMU);
        return s;
    endfunction
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1} state_e;
`endif

    function automatic logic is_long_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
               (op == OP_REM) || (op == OP_REMU);
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider.
// The first iteration happens on the start edge; done flags the cycle computing the last one.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  iter_sel_t        sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] cur_acc, cur_a, cur_b;
    logic [WIDTH-1:0] step_acc, step_a, step_b;
`ifdef ALU_SEQ_DIV_EN
    iter_sel_t        sel_q, sel_d, cur_sel;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [WIDTH:0]   rshift, diff;
    logic             qbit;
`endif

    assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        cur_acc = start ? '0 : acc_q;
        cur_a   = start ? a : opa_q;
        cur_b   = start ? b : opb_q;
`ifdef ALU_SEQ_DIV_EN
        cur_sel = start ? sel : sel_q;
        if (start && sel.sgn) begin
            cur_a = a[WIDTH-1] ? -a : a;
            cur_b = b[WIDTH-1] ? -b : b;
        end
        rshift = {cur_acc, cur_a[WIDTH-1]};
        diff   = rshift - {1'b0, cur_b};
        qbit   = !diff[WIDTH];
`endif
        step_acc = cur_acc + (cur_b[0] ? cur_a : '0);
        step_a   = cur_a << 1;
        step_b   = cur_b >> 1;
`ifdef ALU_SEQ_DIV_EN
        // Dividend bits shift out of opa while quotient bits shift in behind them
        if (cur_sel.div) begin
            step_acc = qbit ? diff[WIDTH-1:0] : rshift[WIDTH-1:0];
            step_a   = {cur_a[WIDTH-2:0], qbit};
            step_b   = cur_b;
        end
`endif
    end

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
`ifdef ALU_SEQ_DIV_EN
        sel_d     = sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        if (start) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(1);
            acc_d = step_acc;
            opa_d = step_a;
            opb_d = step_b;
`ifdef ALU_SEQ_DIV_EN
            sel_d     = sel;
            // Divide-by-zero keeps an all-ones quotient; remainder sign follows the dividend
            neg_quo_d = sel.sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            neg_rem_d = sel.sgn && a[WIDTH-1];
`endif
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = step_acc;
            opa_d = step_a;
            opb_d = step_b;
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_comb begin
        result = step_acc;
`ifdef ALU_SEQ_DIV_EN
        if (sel_q.div) begin
            if (sel_q.rem) begin
                result = neg_rem_q ? -step_acc : step_acc;
            end else begin
                result = neg_quo_q ? -step_a : step_a;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            sel_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
`ifdef ALU_SEQ_DIV_EN
            sel_q     <= sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle RV32-style ALU with valid/ready handshakes on both sides.
// Divide/remainder ops are present only when ALU_SEQ_DIV_EN is defined.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] single_res, iter_res;
    logic             accept, long_op, iter_done;
    logic [SH_W-1:0]  shamt;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign long_op   = is_long_op(alu_op);
    assign shamt     = rs2[SH_W-1:0];
    assign out_valid = out_valid_q;
    assign alu_res   = res_q;
    assign zero      = zero_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        single_res = '0;
        case (alu_op)
            OP_ADD:  single_res = rs1 + rs2;
            OP_SUB:  single_res = rs1 - rs2;
            OP_AND:  single_res = rs1 & rs2;
            OP_OR:   single_res = rs1 | rs2;
            OP_XOR:  single_res = rs1 ^ rs2;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, rs1 < rs2};
            OP_SLL:  single_res = rs1 << shamt;
            OP_SRL:  single_res = rs1 >> shamt;
            OP_SRA:  single_res = $signed(rs1) >>> shamt;
            default: single_res = '0;
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && long_op),
`ifdef ALU_SEQ_DIV_EN
        .sel    (iter_sel(alu_op)),
`endif
        .a      (rs1),
        .b      (rs2),
        .done   (iter_done),
        .result (iter_res)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        res_d       = res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    zero_d = (rs1 == rs2);
                    if (long_op) begin
                        out_valid_d = 1'b0;
`ifdef ALU_SEQ_DIV_EN
                        state_d = (alu_op == OP_MUL) ? ST_MUL : ST_DIV;
`else
                        state_d = ST_MUL;
`endif
                    end else begin
                        res_d       = single_res;
                        out_valid_d = 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                if (iter_done) begin
                    res_d       = iter_res;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            res_q       <= res_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against a reference model.
// Divide cases are exercised as real ops or as undefined ops depending on ALU_SEQ_DIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   alu_op = 4'd0;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         in_ready, out_valid, zero, busy;
    logic [W-1:0] alu_res;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_res   (alu_res),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return sa >>> b[4:0];
            OP_MUL:  return a * b;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        if (op == OP_MUL || op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) return W;
`else
        if (op == OP_MUL) return W;
`endif
        return 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready high, measure latency, check result and flags.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int guard, lat, want_lat;
        bit ready_seen;
        want_lat = exp_lat(op);
        alu_op   = op;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        alu_op   = 4'($urandom);
        lat        = 1;
        ready_seen = 1'b0;
        if (want_lat != 1) check({tag, "/busy"}, 64'(busy), 64'd1);
        while (!out_valid && lat < 2 * W + 8) begin
            ready_seen = ready_seen | in_ready;
            tick();
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(want_lat));
        check({tag, "/res"}, 64'(alu_res), 64'(exp));
        check({tag, "/zero"}, 64'(zero), 64'(a == b));
        if (want_lat != 1) check({tag, "/ready_low"}, 64'(ready_seen), 64'd0);
        $display("op=%0d a=0x%08h b=0x%08h res=0x%08h zero=%0b lat=%0d", op, a, b, alu_res, zero, lat);
        tick();
        check({tag, "/drain"}, {62'd0, out_valid, busy}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] a, b, sum;
        logic [3:0]   op;

        repeat (3) tick();
        check("reset/outs", {29'd0, out_valid, zero, busy, alu_res}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("reset/in_ready", 64'(in_ready), 64'd1);

        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("sra", OP_SRA, 32'h8000_00F0, 32'h0000_0024, 32'hF800_000F);
        run_op("undef", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
        run_op("mul", OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        run_op("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
`ifdef ALU_SEQ_DIV_EN
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_z", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_z", OP_REMU, 32'd7, 32'd0, 32'd7);
        run_op("div_z", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_z", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
`else
        run_op("div_undef", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0);
        run_op("remu_undef", OP_REMU, 32'd7, 32'd0, 32'd0);
`endif

        // Backpressure: result and zero hold while the next request waits
        out_ready = 1'b0;
        alu_op    = OP_ADD;
        rs1       = 32'h10;
        rs2       = 32'h10;
        in_valid  = 1'b1;
        tick();
        alu_op = OP_SUB;
        rs1    = 32'd9;
        rs2    = 32'd4;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp/hold%0d", i), {29'd0, in_ready, out_valid, zero, alu_res},
                  {29'd0, 1'b0, 1'b1, 1'b1, 32'h20});
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp/take_and_accept", {30'd0, out_valid, zero, alu_res}, {30'd0, 1'b1, 1'b0, 32'd5});
        $display("op=%0d a=0x%08h b=0x%08h res=0x%08h zero=%0b lat=%0d", OP_SUB, 32'd9, 32'd4, alu_res, zero, 1);
        tick();
        check("bp/drain", 64'(out_valid), 64'd0);

        // Back-to-back single-cycle ops, one result per cycle
        alu_op   = OP_ADD;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = $urandom;
            sum = a + b;
            rs1 = a;
            rs2 = b;
            tick();
            check($sformatf("b2b%0d", i), {30'd0, out_valid, in_ready, alu_res}, {30'd0, 1'b1, 1'b1, sum});
            $display("op=%0d a=0x%08h b=0x%08h res=0x%08h zero=%0b lat=%0d", OP_ADD, a, b, alu_res, zero, 1);
        end
        in_valid = 1'b0;
        tick();

        run_op("beq", OP_ADD, 32'h1234, 32'h1234, 32'h2468);

        // Reset in the middle of a multiply
        alu_op   = OP_MUL;
        rs1      = 32'd5;
        rs2      = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("rst_mid/busy", 64'(busy), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid/outs", {29'd0, out_valid, zero, busy, alu_res}, 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check("rst_mid/after", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
        run_op("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 32'($urandom_range(0, 3));
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
